// File: rtl/wb_pkg.sv
// Shared codes for the writeback stage: memtoreg selectors, load funct3 encodings
// and the byte-offset width helper.
package wb_pkg;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_LOAD = 2'b01,
    MTR_PC4  = 2'b10,
    MTR_RSVD = 2'b11
  } memtoreg_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned OFF_W    = $clog2(XLEN_DEF / 8);

  // Byte-offset width for an arbitrary datapath width.
  function automatic int unsigned off_w(input int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte-lane load extraction: shift the raw memory word by the byte offset,
// then sign/zero-extend per funct3. Misalign flag exists only with WB_MISALIGN_CHECK_EN.
module load_extract
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]          rdata,
  input  logic [off_w(XLEN)-1:0]   offset,
  input  logic [2:0]               funct3,
  output logic [XLEN-1:0]          result
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic                     misalign
`endif
);

  localparam int unsigned OffW = off_w(XLEN);

  logic [OffW+2:0] shamt;
  logic [XLEN-1:0] shifted;

  assign shamt   = {offset, 3'b000};
  assign shifted = rdata >> shamt;

  // Keep the low w bits, fill the rest with the (optional) sign bit.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input int w,
                                          input logic sgn);
    logic [XLEN-1:0] r;
    logic            fill;
    fill = sgn & v[w-1];
    for (int i = 0; i < int'(XLEN); i++) begin
      r[i] = (i < w) ? v[i] : fill;
    end
    return r;
  endfunction

  always_comb begin
    result = '0;
    case (funct3)
      LB:      result = ext(shifted, 8, 1'b1);
      LBU:     result = ext(shifted, 8, 1'b0);
      LH:      result = ext(shifted, 16, 1'b1);
      LHU:     result = ext(shifted, 16, 1'b0);
      LW:      result = ext(shifted, 32, 1'b1);
      LWU:     result = (XLEN == 64) ? ext(shifted, 32, 1'b0) : '0;
      LD:      result = (XLEN == 64) ? shifted : '0;
      default: result = '0;
    endcase
  end

`ifdef WB_MISALIGN_CHECK_EN
  logic [OffW-1:0] amask;

  always_comb begin
    amask = '0;
    case (funct3)
      LH, LHU: amask = OffW'(1);
      LW:      amask = OffW'(3);
      LWU:     amask = (XLEN == 64) ? OffW'(3) : '0;
      LD:      amask = (XLEN == 64) ? OffW'(7) : '0;
      default: amask = '0;
    endcase
  end

  assign misalign = |(offset & amask);
`endif

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: MEM/WB register, load extraction, result select, stall/flush
// and retired-instruction counter. Optional alignment check via WB_MISALIGN_CHECK_EN.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alures,
  input  logic [XLEN-1:0]  in_rdata,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_memtoreg,
  input  logic             in_regwrite,
  input  logic [4:0]       in_rd,
  output logic             wb_valid,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] instret
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic             wb_misalign
`endif
);

  localparam int unsigned OffW = off_w(XLEN);

  logic [OffW-1:0]  off;
  logic [XLEN-1:0]  load_res;
  logic [XLEN-1:0]  result;

  logic             valid_q,    valid_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rd_q,       rd_d;
  logic [XLEN-1:0]  wdata_q,    wdata_d;
  logic [CNT_W-1:0] instret_q,  instret_d;

  assign off = in_alures[OffW-1:0];

`ifdef WB_MISALIGN_CHECK_EN
  logic lx_misalign;
  logic misalign_q, misalign_d;
`endif

  load_extract #(
    .XLEN(XLEN)
  ) u_load_extract (
    .rdata   (in_rdata),
    .offset  (off),
    .funct3  (in_funct3),
    .result  (load_res)
`ifdef WB_MISALIGN_CHECK_EN
    ,
    .misalign(lx_misalign)
`endif
  );

  always_comb begin
    result = '0;
    case (in_memtoreg)
      MTR_ALU:  result = in_alures;
      MTR_LOAD: result = load_res;
      // Computed at XLEN so a PC_W overflow carries into bit PC_W.
      MTR_PC4:  result = XLEN'(in_pc) + XLEN'(4);
      default:  result = '0;
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    instret_d  = instret_q;
`ifdef WB_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d    = in_valid;
      regwrite_d = in_regwrite;
      rd_d       = in_rd;
      wdata_d    = result;
      instret_d  = instret_q + CNT_W'(in_valid);
`ifdef WB_MISALIGN_CHECK_EN
      misalign_d = in_valid & (in_memtoreg == MTR_LOAD) & lx_misalign;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      instret_q  <= '0;
`ifdef WB_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      instret_q  <= instret_d;
`ifdef WB_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign wb_valid = valid_q;
  assign rf_waddr = rd_q;
  assign rf_wdata = wdata_q;
  assign instret  = instret_q;

`ifdef WB_MISALIGN_CHECK_EN
  assign wb_misalign = misalign_q;
  assign rf_we       = valid_q & regwrite_q & (rd_q != 5'd0) & ~misalign_q;
`else
  assign rf_we       = valid_q & regwrite_q & (rd_q != 5'd0);
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe (XLEN=64): expected WB state is pushed when each
// cycle is driven and popped after the capturing edge.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_regwrite;
  logic [31:0] in_pc;
  logic [63:0] in_alures, in_rdata;
  logic [2:0]  in_funct3;
  logic [1:0]  in_memtoreg;
  logic [4:0]  in_rd;
  logic        wb_valid, rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata, instret;
`ifdef WB_MISALIGN_CHECK_EN
  logic        wb_misalign;
`endif

  wb_stage_pipe #(
    .XLEN (64),
    .PC_W (32),
    .CNT_W(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_alures  (in_alures),
    .in_rdata   (in_rdata),
    .in_funct3  (in_funct3),
    .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite),
    .in_rd      (in_rd),
    .wb_valid   (wb_valid),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .instret    (instret)
`ifdef WB_MISALIGN_CHECK_EN
    ,
    .wb_misalign(wb_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [63:0] alures;
    logic [63:0] rdata;
    logic [2:0]  f3;
    logic [1:0]  mtr;
    logic        rw;
    logic [4:0]  rd;
  } txn_t;

  typedef struct {
    logic        valid;
    logic        we;
    logic        mis;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] instret;
    logic        chk_data;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [63:0] cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Byte-by-byte reference: bytes past the top of the word read as zero.
  function automatic logic [63:0] ref_load(input logic [63:0] d, input int off,
                                           input logic [2:0] f3);
    int          n;
    logic        sgn;
    logic [63:0] v;
    v = '0;
    case (f3)
      3'b000:  begin n = 1; sgn = 1'b1; end
      3'b100:  begin n = 1; sgn = 1'b0; end
      3'b001:  begin n = 2; sgn = 1'b1; end
      3'b101:  begin n = 2; sgn = 1'b0; end
      3'b010:  begin n = 4; sgn = 1'b1; end
      3'b110:  begin n = 4; sgn = 1'b0; end
      3'b011:  begin n = 8; sgn = 1'b0; end
      default: return 64'd0;
    endcase
    for (int k = 0; k < n; k++) begin
      if (off + k < 8) v[8*k +: 8] = d[8*(off+k) +: 8];
    end
    if (sgn && v[8*n-1]) begin
      for (int b = 8 * n; b < 64; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic ref_misalign(input int off, input logic [2:0] f3);
    int n;
    case (f3)
      3'b001, 3'b101:  n = 2;
      3'b010, 3'b110:  n = 4;
      3'b011:          n = 8;
      default:         n = 1;
    endcase
    return (off % n) != 0;
  endfunction

  task automatic cycle(input txn_t t, input logic s, input logic f, input logic r);
    exp_t e;
    exp_t got;
    rst = r; stall = s; flush = f;
    in_valid = t.valid; in_pc = t.pc; in_alures = t.alures; in_rdata = t.rdata;
    in_funct3 = t.f3; in_memtoreg = t.mtr; in_regwrite = t.rw; in_rd = t.rd;
    if (r) begin
      e = '{valid: 1'b0, we: 1'b0, mis: 1'b0, waddr: 5'd0, wdata: 64'd0, instret: 64'd0,
            chk_data: 1'b1};
      cnt = 64'd0;
    end else if (f) begin
      e = last;
      e.valid = 1'b0; e.we = 1'b0; e.chk_data = 1'b0;
    end else if (s) begin
      e = last;
    end else begin
      e.valid = t.valid;
      e.waddr = t.rd;
      case (t.mtr)
        2'b00:   e.wdata = t.alures;
        2'b01:   e.wdata = ref_load(t.rdata, int'(t.alures[2:0]), t.f3);
        2'b10:   e.wdata = {32'd0, t.pc} + 64'd4;
        default: e.wdata = 64'd0;
      endcase
`ifdef WB_MISALIGN_CHECK_EN
      e.mis = t.valid && t.mtr == 2'b01 && ref_misalign(int'(t.alures[2:0]), t.f3);
`else
      e.mis = 1'b0;
`endif
      e.we = t.valid && t.rw && t.rd != 5'd0 && !e.mis;
      e.chk_data = 1'b1;
      if (t.valid) cnt = cnt + 64'd1;
    end
    e.instret = cnt;
    last = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq("wb_valid", {63'd0, wb_valid}, {63'd0, got.valid});
    check_eq("rf_we", {63'd0, rf_we}, {63'd0, got.we});
    check_eq("instret", instret, got.instret);
    if (got.chk_data) begin
      check_eq("rf_waddr", {59'd0, rf_waddr}, {59'd0, got.waddr});
      check_eq("rf_wdata", rf_wdata, got.wdata);
`ifdef WB_MISALIGN_CHECK_EN
      check_eq("wb_misalign", {63'd0, wb_misalign}, {63'd0, got.mis});
`endif
    end
  endtask

  function automatic txn_t mk(input logic v, input logic [31:0] pc, input logic [63:0] a,
                              input logic [63:0] d, input logic [2:0] f3,
                              input logic [1:0] mtr, input logic rw, input logic [4:0] rd);
    txn_t t;
    t = '{valid: v, pc: pc, alures: a, rdata: d, f3: f3, mtr: mtr, rw: rw, rd: rd};
    return t;
  endfunction

  initial begin
    txn_t idle;
    txn_t t;
    idle = mk(1'b0, 32'd0, 64'd0, 64'd0, 3'd0, 2'd0, 1'b0, 5'd0);
    cnt  = 64'd0;
    last = '{valid: 1'b0, we: 1'b0, mis: 1'b0, waddr: 5'd0, wdata: 64'd0, instret: 64'd0,
             chk_data: 1'b1};
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_alures = '0; in_rdata = '0;
    in_funct3 = '0; in_memtoreg = '0; in_regwrite = 1'b0; in_rd = '0;
    @(posedge clk); #1;
    cycle(idle, 1'b0, 1'b0, 1'b1);

    // Directed loads, PC+4 and x0 destination.
    cycle(mk(1'b1, 32'h100, 64'h1000_0003, 64'h0011_2233_8455_6677, 3'b000, 2'b01, 1'b1, 5'd5),
          1'b0, 1'b0, 1'b0);
    check_eq("lb_value", rf_wdata, 64'hFFFF_FFFF_FFFF_FF84);
    cycle(mk(1'b1, 32'h104, 64'h1000_0003, 64'h0011_2233_8455_6677, 3'b100, 2'b01, 1'b1, 5'd6),
          1'b0, 1'b0, 1'b0);
    check_eq("lbu_value", rf_wdata, 64'h84);
    cycle(mk(1'b1, 32'h108, 64'h2000_0004, 64'h8000_0001_1234_5678, 3'b010, 2'b01, 1'b1, 5'd7),
          1'b0, 1'b0, 1'b0);
    check_eq("lw_value", rf_wdata, 64'hFFFF_FFFF_8000_0001);
    cycle(mk(1'b1, 32'h10C, 64'h2000_0004, 64'h8000_0001_1234_5678, 3'b110, 2'b01, 1'b1, 5'd8),
          1'b0, 1'b0, 1'b0);
    check_eq("lwu_value", rf_wdata, 64'h0000_0000_8000_0001);
    cycle(mk(1'b1, 32'hFFFF_FFFC, 64'h0, 64'h0, 3'b000, 2'b10, 1'b1, 5'd1),
          1'b0, 1'b0, 1'b0);
    check_eq("pc4_carry", rf_wdata, 64'h0000_0001_0000_0000);
    check_eq("instret_5", instret, 64'd5);
    cycle(mk(1'b1, 32'h110, 64'hDEAD_BEEF, 64'h0, 3'b000, 2'b00, 1'b1, 5'd0),
          1'b0, 1'b0, 1'b0);
    check_eq("x0_we", {63'd0, rf_we}, 64'd0);
    check_eq("x0_instret", instret, 64'd6);

    // Randomised mix of ALU, load, PC+4 and reserved selects.
    for (int i = 0; i < 40; i++) begin
      t = mk(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, {$urandom, $urandom},
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)));
      cycle(t, 1'b0, 1'b0, 1'b0);
    end

    // Stall for three cycles while new instructions are offered.
    cycle(mk(1'b1, 32'h200, 64'h1234, 64'h0, 3'b000, 2'b00, 1'b1, 5'd9), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1'b1, 32'h204, 64'h5555 + 64'(i), 64'h0, 3'b000, 2'b00, 1'b1, 5'd10),
            1'b1, 1'b0, 1'b0);
    end
    check_eq("stall_hold", rf_wdata, 64'h1234);
    cycle(mk(1'b1, 32'h208, 64'h7777, 64'h0, 3'b000, 2'b00, 1'b1, 5'd11), 1'b1, 1'b1, 1'b0);
    cycle(mk(1'b1, 32'h20C, 64'h8888, 64'h0, 3'b000, 2'b00, 1'b1, 5'd12), 1'b0, 1'b0, 1'b0);

    // Reset mid-stream with a valid instruction on the inputs.
    cycle(mk(1'b1, 32'h210, 64'h9999, 64'h0, 3'b000, 2'b00, 1'b1, 5'd13), 1'b0, 1'b0, 1'b1);
    check_eq("rst_instret", instret, 64'd0);

    // LH at offset 1.
    cycle(mk(1'b1, 32'h300, 64'h4000_0001, 64'h0011_2233_8455_6677, 3'b001, 2'b01, 1'b1, 5'd3),
          1'b0, 1'b0, 1'b0);
`ifdef WB_MISALIGN_CHECK_EN
    check_eq("lh_mis_flag", {63'd0, wb_misalign}, 64'd1);
    check_eq("lh_mis_we", {63'd0, rf_we}, 64'd0);
`else
    check_eq("lh_off1_value", rf_wdata, 64'h5566);
`endif
    cycle(idle, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
